// File: rtl/exu_mdu_stage.sv
// exu_mdu_stage: execute stage between IDU and LSU.
// Single-cycle ALU and compare ops complete in one cycle. When the macro
// EXU_M_EXT_EN is defined, RV32M-style multiply/divide ops run iteratively
// (one bit per cycle). Without it, M op codes are reported as illegal.
// Each result lands in a registered output slot with a valid/ready
// handshake, and an opaque sideband tag travels with every op.
module exu_mdu_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 48,
    parameter int OP_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_pre_valid,
    output logic             o_pre_ready,
    output logic             o_post_valid,
    input  logic             i_post_ready,
    input  logic [OP_W-1:0]  i_op,
    input  logic [XLEN-1:0]  i_src1,
    input  logic [XLEN-1:0]  i_src2,
    input  logic [TAG_W-1:0] i_tag,
    output logic [XLEN-1:0]  o_res,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_illegal,
    output logic             o_busy
);
    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0]  shamt_s;
    logic [XLEN-1:0]  alu_res_s;
    logic             alu_ill_s;
    logic             is_m_s;
    logic             idle_s;
    logic             accept_s;
    logic             take_s;
    logic             done_s;
    logic [XLEN-1:0]  m_res_s;
    logic [TAG_W-1:0] m_tag_s;

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             ill_q, ill_d;

    assign shamt_s     = i_src2[SH_W-1:0];
    assign o_pre_ready = idle_s && (!valid_q || i_post_ready);
    assign accept_s    = i_pre_valid && o_pre_ready;
    assign take_s      = valid_q && i_post_ready;

    // Single-cycle ALU/compare result and op classification
    always_comb begin
        alu_res_s = '0;
        alu_ill_s = 1'b0;
        is_m_s    = 1'b0;
        case (i_op)
            5'd0:  alu_res_s = i_src1 + i_src2;
            5'd1:  alu_res_s = i_src1 - i_src2;
            5'd2:  alu_res_s = i_src1 << shamt_s;
            5'd3:  alu_res_s = i_src1 ^ i_src2;
            5'd4:  alu_res_s = i_src1 >> shamt_s;
            5'd5:  alu_res_s = $signed(i_src1) >>> shamt_s;
            5'd6:  alu_res_s = i_src1 | i_src2;
            5'd7:  alu_res_s = i_src1 & i_src2;
            5'd8:  alu_res_s[0] = (i_src1 == i_src2);
            5'd9:  alu_res_s[0] = (i_src1 != i_src2);
            5'd10: alu_res_s[0] = ($signed(i_src1) < $signed(i_src2));
            5'd11: alu_res_s[0] = ($signed(i_src1) >= $signed(i_src2));
            5'd12: alu_res_s[0] = (i_src1 < i_src2);
            5'd13: alu_res_s[0] = (i_src1 >= i_src2);
`ifdef EXU_M_EXT_EN
            5'd16, 5'd17, 5'd18, 5'd19,
            5'd20, 5'd21, 5'd22, 5'd23: is_m_s = 1'b1;
`endif
            default: alu_ill_s = 1'b1;
        endcase
    end

`ifdef EXU_M_EXT_EN
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_CALC = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         mop_q, mop_d;
    logic               a_neg_q, a_neg_d, b_neg_q, b_neg_d, dz_q, dz_d;
    logic [XLEN-1:0]    src1_q, src1_d, mcand_q, mcand_d;
    logic [XLEN-1:0]    p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic [TAG_W-1:0]   mtag_q, mtag_d;

    logic               a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]    a_mag_s, b_mag_s, step_hi_s, step_lo_s, quo_s, rem_s;
    logic [XLEN:0]      mul_sum_s, div_shift_s, div_diff_s;
    logic [2*XLEN-1:0]  prod_s;

    assign idle_s  = (state_q == ST_IDLE);
    assign o_busy  = (state_q == ST_CALC);
    assign m_tag_s = mtag_q;

    // Operand signedness and magnitudes of the op currently offered
    always_comb begin
        a_sgn_s = 1'b1;
        b_sgn_s = 1'b1;
        case (i_op[2:0])
            3'd2:             b_sgn_s = 1'b0;
            3'd3, 3'd5, 3'd7: begin a_sgn_s = 1'b0; b_sgn_s = 1'b0; end
            default:          a_sgn_s = 1'b1;
        endcase
        a_neg_s = a_sgn_s && i_src1[XLEN-1];
        b_neg_s = b_sgn_s && i_src2[XLEN-1];
        a_mag_s = a_neg_s ? (-i_src1) : i_src1;
        b_mag_s = b_neg_s ? (-i_src2) : i_src2;
    end

    // One iteration (shift-add or restoring subtract) and final sign fix-up
    always_comb begin
        mul_sum_s   = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        div_shift_s = {p_hi_q, p_lo_q[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, mcand_q};
        if (mop_q[2]) begin
            // A set top bit of the difference means the subtract borrowed.
            if (!div_diff_s[XLEN]) begin
                step_hi_s = div_diff_s[XLEN-1:0];
                step_lo_s = {p_lo_q[XLEN-2:0], 1'b1};
            end else begin
                step_hi_s = div_shift_s[XLEN-1:0];
                step_lo_s = {p_lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi_s = mul_sum_s[XLEN:1];
            step_lo_s = {mul_sum_s[0], p_lo_q[XLEN-1:1]};
        end
        prod_s = {step_hi_s, step_lo_s};
        quo_s  = step_lo_s;
        rem_s  = step_hi_s;
        if (a_neg_q ^ b_neg_q) begin
            prod_s = -prod_s;
            quo_s  = -quo_s;
        end else begin
            prod_s = {step_hi_s, step_lo_s};
        end
        if (a_neg_q) begin
            rem_s = -rem_s;
        end else begin
            rem_s = step_hi_s;
        end
        // Signed overflow falls out of the magnitude path naturally;
        // only divide-by-zero needs an override.
        if (dz_q) begin
            quo_s = '1;
            rem_s = src1_q;
        end else begin
            quo_s = quo_s;
        end
        case (mop_q)
            3'd0:             m_res_s = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: m_res_s = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       m_res_s = quo_s;
            default:          m_res_s = rem_s;
        endcase
    end

    // IDLE/CALC sequencing, operand latch and iteration counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mop_d   = mop_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        dz_d    = dz_q;
        src1_d  = src1_q;
        mcand_d = mcand_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        mtag_d  = mtag_q;
        done_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && is_m_s) begin
                    state_d = ST_CALC;
                    cnt_d   = CNT_W'(XLEN);
                    mop_d   = i_op[2:0];
                    a_neg_d = a_neg_s;
                    b_neg_d = b_neg_s;
                    dz_d    = i_op[2] && (i_src2 == '0);
                    src1_d  = i_src1;
                    mtag_d  = i_tag;
                    p_hi_d  = '0;
                    // Divide: dividend shifts out of p_lo; multiply: multiplier does.
                    p_lo_d  = i_op[2] ? a_mag_s : b_mag_s;
                    mcand_d = i_op[2] ? b_mag_s : a_mag_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                p_hi_d = step_hi_s;
                p_lo_d = step_lo_s;
                cnt_d  = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    done_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Multiply/divide state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mop_q   <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            src1_q  <= '0;
            mcand_q <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            mtag_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mop_q   <= mop_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            dz_q    <= dz_d;
            src1_q  <= src1_d;
            mcand_q <= mcand_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            mtag_q  <= mtag_d;
        end
    end
`else
    assign idle_s  = 1'b1;
    assign o_busy  = 1'b0;
    assign done_s  = 1'b0;
    assign m_res_s = '0;
    assign m_tag_s = '0;
`endif

    // Output slot: load on completion, clear on a take with no new load
    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        tag_d   = tag_q;
        ill_d   = ill_q;
        if (done_s) begin
            valid_d = 1'b1;
            res_d   = m_res_s;
            tag_d   = m_tag_s;
            ill_d   = 1'b0;
        end else if (accept_s && !is_m_s) begin
            valid_d = 1'b1;
            res_d   = alu_res_s;
            tag_d   = i_tag;
            ill_d   = alu_ill_s;
        end else if (take_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output slot registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            tag_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
            ill_q   <= ill_d;
        end
    end

    assign o_post_valid = valid_q;
    assign o_res        = res_q;
    assign o_tag        = tag_q;
    assign o_illegal    = ill_q;

endmodule

// File: tb/tb_exu_mdu_stage.sv
// Directed bench for exu_mdu_stage at default parameters (XLEN=32, TAG_W=48).
// M-op expectations follow the EXU_M_EXT_EN build setting.
module tb_exu_mdu_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_pre_valid = 1'b0;
    logic        o_pre_ready;
    logic        o_post_valid;
    logic        i_post_ready = 1'b1;
    logic [4:0]  i_op = 5'd0;
    logic [31:0] i_src1 = 32'd0;
    logic [31:0] i_src2 = 32'd0;
    logic [47:0] i_tag = 48'd0;
    logic [31:0] o_res;
    logic [47:0] o_tag;
    logic        o_illegal;
    logic        o_busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        ill;
    } vec_t;

    vec_t vecs [16];

    always #5 clk = ~clk;

    exu_mdu_stage dut (
        .clk          (clk),
        .rst          (rst),
        .i_pre_valid  (i_pre_valid),
        .o_pre_ready  (o_pre_ready),
        .o_post_valid (o_post_valid),
        .i_post_ready (i_post_ready),
        .i_op         (i_op),
        .i_src1       (i_src1),
        .i_src2       (i_src2),
        .i_tag        (i_tag),
        .o_res        (o_res),
        .o_tag        (o_tag),
        .o_illegal    (o_illegal),
        .o_busy       (o_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] tag_of(input int i);
        return 48'hABC | (48'(i) << 32);
    endfunction

`ifdef EXU_M_EXT_EN
    task automatic m_run(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [47:0] tg, input logic [31:0] exp);
        int lat;
        int busy;
        @(negedge clk);
        chk({name, "_rdy"}, 64'(o_pre_ready), 64'd1);
        i_pre_valid = 1'b1; i_op = op; i_src1 = a; i_src2 = b; i_tag = tg;
        @(negedge clk);
        i_pre_valid = 1'b0;
        lat  = 1;
        busy = 0;
        while (!o_post_valid && lat < 40) begin
            if (o_busy) busy++;
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"},  64'(lat),  64'd33);
        chk({name, "_busy"}, 64'(busy), 64'd32);
        chk({name, "_res"},  64'(o_res), 64'(exp));
        chk({name, "_tag"},  64'(o_tag), 64'(tg));
        chk({name, "_ill"},  64'(o_illegal), 64'd0);
    endtask
`endif

    initial begin
        vecs[0]  = '{5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
        vecs[1]  = '{5'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0};
        vecs[2]  = '{5'd2,  32'h00000001, 32'h0000003F, 32'h80000000, 1'b0};
        vecs[3]  = '{5'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
        vecs[4]  = '{5'd4,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0};
        vecs[5]  = '{5'd5,  32'hF0000000, 32'h00000004, 32'hFF000000, 1'b0};
        vecs[6]  = '{5'd6,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0};
        vecs[7]  = '{5'd7,  32'h12345678, 32'h0000FFFF, 32'h00005678, 1'b0};
        vecs[8]  = '{5'd8,  32'h00000005, 32'h00000005, 32'h00000001, 1'b0};
        vecs[9]  = '{5'd9,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
        vecs[10] = '{5'd10, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[11] = '{5'd11, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
        vecs[12] = '{5'd12, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
        vecs[13] = '{5'd13, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[14] = '{5'd30, 32'h00000001, 32'h00000002, 32'h00000000, 1'b1};
        vecs[15] = '{5'd15, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(o_post_valid), 64'd0);
        chk("rst_res",   64'(o_res),        64'd0);
        chk("rst_tag",   64'(o_tag),        64'd0);
        chk("rst_ill",   64'(o_illegal),    64'd0);
        chk("rst_busy",  64'(o_busy),       64'd0);
        chk("rst_rdy",   64'(o_pre_ready),  64'd1);

        // Back-to-back single-cycle ops, one result per cycle
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("v%0d_valid", i-1), 64'(o_post_valid), 64'd1);
                chk($sformatf("v%0d_res", i-1),   64'(o_res),        64'(vecs[i-1].r));
                chk($sformatf("v%0d_tag", i-1),   64'(o_tag),        64'(tag_of(i-1)));
                chk($sformatf("v%0d_ill", i-1),   64'(o_illegal),    64'(vecs[i-1].ill));
            end
            if (i < 16) begin
                chk($sformatf("v%0d_rdy", i), 64'(o_pre_ready), 64'd1);
                i_pre_valid = 1'b1;
                i_op   = vecs[i].op;
                i_src1 = vecs[i].a;
                i_src2 = vecs[i].b;
                i_tag  = tag_of(i);
            end else begin
                i_pre_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("stream_empty", 64'(o_post_valid), 64'd0);

        // SRA held under back-pressure, a pending ADD must wait
        i_post_ready = 1'b0;
        i_pre_valid = 1'b1; i_op = 5'd5; i_src1 = 32'h80000000; i_src2 = 32'd31; i_tag = 48'h55;
        @(negedge clk);
        i_op = 5'd0; i_src1 = 32'd3; i_src2 = 32'd4; i_tag = 48'h66;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 64'(o_post_valid), 64'd1);
            chk("stall_res",   64'(o_res),        64'hFFFFFFFF);
            chk("stall_tag",   64'(o_tag),        64'h55);
            chk("stall_rdy",   64'(o_pre_ready),  64'd0);
            @(negedge clk);
        end
        i_post_ready = 1'b1;
        @(negedge clk);
        i_pre_valid = 1'b0;
        chk("reload_valid", 64'(o_post_valid), 64'd1);
        chk("reload_res",   64'(o_res),        64'd7);
        chk("reload_tag",   64'(o_tag),        64'h66);
        @(negedge clk);
        chk("release_empty", 64'(o_post_valid), 64'd0);

`ifdef EXU_M_EXT_EN
        m_run("mulh_m1",  5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 48'h101, 32'h00000000);
        m_run("mul_6x7",  5'd16, 32'd6,        32'd7,        48'h102, 32'd42);
        m_run("mulhu",    5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 48'h103, 32'hFFFFFFFE);
        m_run("mulhsu",   5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 48'h104, 32'hFFFFFFFF);
        m_run("div_z",    5'd20, 32'd7,        32'd0,        48'h105, 32'hFFFFFFFF);
        m_run("rem_z",    5'd22, 32'd7,        32'd0,        48'h106, 32'd7);
        m_run("div_ovf",  5'd20, 32'h80000000, 32'hFFFFFFFF, 48'h107, 32'h80000000);
        m_run("rem_neg",  5'd22, 32'hFFFFFFF9, 32'd2,        48'h108, 32'hFFFFFFFF);
        m_run("div_neg",  5'd20, 32'hFFFFFFF9, 32'd2,        48'h109, 32'hFFFFFFFD);
        m_run("divu",     5'd21, 32'd100,      32'd3,        48'h10A, 32'd33);
        m_run("remu",     5'd23, 32'd100,      32'd3,        48'h10B, 32'd1);

        // Reset in the middle of a DIVU discards it
        begin
            int spurious;
            @(negedge clk);
            i_pre_valid = 1'b1; i_op = 5'd21; i_src1 = 32'd100; i_src2 = 32'd3; i_tag = 48'h200;
            @(negedge clk);
            i_pre_valid = 1'b0;
            repeat (9) @(negedge clk);
            chk("abort_busy_pre", 64'(o_busy), 64'd1);
            rst = 1'b1;
            @(negedge clk);
            chk("abort_busy",  64'(o_busy),       64'd0);
            chk("abort_valid", 64'(o_post_valid), 64'd0);
            chk("abort_rdy",   64'(o_pre_ready),  64'd1);
            rst = 1'b0;
            spurious = 0;
            repeat (40) begin
                @(negedge clk);
                if (o_post_valid) spurious++;
            end
            chk("abort_spurious", 64'(spurious), 64'd0);
        end
`else
        // M ops are illegal single-cycle ops in this build
        @(negedge clk);
        i_pre_valid = 1'b1; i_op = 5'd16; i_src1 = 32'd6; i_src2 = 32'd7; i_tag = 48'h77;
        @(negedge clk);
        i_pre_valid = 1'b0;
        chk("nom_valid", 64'(o_post_valid), 64'd1);
        chk("nom_ill",   64'(o_illegal),    64'd1);
        chk("nom_res",   64'(o_res),        64'd0);
        chk("nom_tag",   64'(o_tag),        64'h77);
        chk("nom_busy",  64'(o_busy),       64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
